// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader: opcodes,
// format and FSM enums, the latched request record and small helpers.
package instr_encoder_loader_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_BAD = 3'd6
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_WRITE  = 2'd2
   } state_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_req_t;

   function automatic fmt_e decode_fmt(input logic [6:0] op);
      fmt_e f;
      case (op)
         OP_R:                      f = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
         OP_STORE:                  f = FMT_S;
         OP_BRANCH:                 f = FMT_B;
         OP_LUI, OP_AUIPC:          f = FMT_U;
         OP_JAL:                    f = FMT_J;
         default:                   f = FMT_BAD;
      endcase
      return f;
   endfunction

   // True when v is representable as a two's-complement value of 'bits' bits.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic signed [31:0] sh;
      sh = $signed(v) >>> (bits - 32'd1);
      return (sh == 32'sd0) || (sh == -32'sd1);
   endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I format decode and field packing; with
// INSTR_ENC_RANGE_CHECK_EN defined it also flags out-of-range immediates.
module instr_field_packer
   import instr_encoder_loader_pkg::*;
(
   input  enc_req_t    i_req,
   output logic [31:0] o_word,
   output logic        o_err
);

   fmt_e        w_fmt;
   logic [31:0] w_imm;
   logic        w_range_err;

   assign w_fmt = decode_fmt(i_req.opcode);
   assign w_imm = i_req.imm;

   always_comb begin
      o_word = 32'h0000_0000;
      case (w_fmt)
         FMT_R: o_word = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3,
                          i_req.rd, i_req.opcode};
         FMT_I: o_word = {w_imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
         FMT_S: o_word = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3,
                          w_imm[4:0], i_req.opcode};
         FMT_B: o_word = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                          w_imm[4:1], w_imm[11], i_req.opcode};
         FMT_U: o_word = {w_imm[31:12], i_req.rd, i_req.opcode};
         FMT_J: o_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                          i_req.rd, i_req.opcode};
         default: o_word = 32'h0000_0000;
      endcase
   end

`ifdef INSTR_ENC_RANGE_CHECK_EN
   // B/J offsets must be even since bit 0 has no slot in the encoding.
   always_comb begin
      w_range_err = 1'b0;
      case (w_fmt)
         FMT_I, FMT_S: w_range_err = !fits_signed(w_imm, 32'd12);
         FMT_B:        w_range_err = !fits_signed(w_imm, 32'd13) || w_imm[0];
         FMT_J:        w_range_err = !fits_signed(w_imm, 32'd21) || w_imm[0];
         FMT_U:        w_range_err = (w_imm[11:0] != 12'h000);
         default:      w_range_err = 1'b0;
      endcase
   end
`else
   assign w_range_err = 1'b0;
`endif

   assign o_err = (w_fmt == FMT_BAD) || w_range_err;

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts RV32I field requests, encodes them and writes the words to
// sequential memory addresses. Optional macro: INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            in_opcode,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [31:0]           in_imm,
   input  logic                  flush,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   output logic                  busy,
   output logic                  err_pulse,
   output logic                  err_sticky,
   output logic [15:0]           instr_count
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

   state_e                r_state;
   state_e                w_state_nxt;
   enc_req_t              r_req;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [15:0]           r_count;
   logic                  r_err_pulse;
   logic                  r_err_sticky;

   logic                  w_accept;
   logic                  w_enc_ok;
   logic                  w_enc_fail;
   logic                  w_wr_done;
   logic [31:0]           w_pack_word;
   logic                  w_pack_err;

   instr_field_packer u_packer (
      .i_req  (r_req),
      .o_word (w_pack_word),
      .o_err  (w_pack_err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Flush overrides every state, including an ack arriving in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_enc_ok    = 1'b0;
      w_enc_fail  = 1'b0;
      w_wr_done   = 1'b0;
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_ready) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_ENCODE;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_ENCODE: begin
               if (w_pack_err) begin
                  w_enc_fail  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_enc_ok    = 1'b1;
                  w_state_nxt = ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  w_wr_done   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_WRITE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Handshake/status outputs are registered from the next state so they
   // line up with r_state; ready stays low for the whole reset assertion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ready      <= 1'b0;
         r_busy       <= 1'b0;
         r_we         <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_err_sticky <= 1'b0;
         r_addr       <= BASE_ADDR;
         r_count      <= 16'h0000;
         r_wdata      <= 32'h0000_0000;
         r_req        <= '0;
      end else begin
         r_ready     <= (w_state_nxt == ST_IDLE);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_we        <= (w_state_nxt == ST_WRITE);
         r_err_pulse <= w_enc_fail;
         if (w_accept) begin
            r_req <= '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                       funct3: in_funct3, funct7: in_funct7, imm: in_imm};
         end
         if (w_enc_ok) begin
            r_wdata <= w_pack_word;
         end
         if (flush) begin
            r_addr       <= BASE_ADDR;
            r_count      <= 16'h0000;
            r_err_sticky <= 1'b0;
         end else begin
            if (w_wr_done) begin
               r_addr <= r_addr + ADDR_STEP;
               if (r_count != 16'hFFFF) begin
                  r_count <= r_count + 16'd1;
               end
            end
            if (w_enc_fail) begin
               r_err_sticky <= 1'b1;
            end
         end
      end
   end

   assign in_ready    = r_ready;
   assign busy        = r_busy;
   assign mem_we      = r_we;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign err_pulse   = r_err_pulse;
   assign err_sticky  = r_err_sticky;
   assign instr_count = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader; a second instance
// with ADDR_WIDTH=4, BASE_ADDR=0xC shares all inputs to cover address wrap.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [6:0]  in_opcode = 7'h00;
   logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
   logic [2:0]  in_funct3 = 3'd0;
   logic [6:0]  in_funct7 = 7'd0;
   logic [31:0] in_imm = 32'd0;
   logic        flush = 1'b0;
   logic        mem_ack = 1'b0;

   logic        in_ready, mem_we, busy, err_pulse, err_sticky;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] instr_count;

   logic        ready4, we4, busy4, ep4, es4;
   logic [3:0]  addr4;
   logic [31:0] wdata4;
   logic [15:0] cnt4;

   int          checks = 0;
   int          errors = 0;
   logic [9:0]  exp_addr = 10'h000;
   logic [3:0]  exp_addr4 = 4'hC;
   logic [15:0] exp_count = 16'd0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_WIDTH(10), .BASE_ADDR(10'h000)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .flush(flush), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .busy(busy), .err_pulse(err_pulse),
      .err_sticky(err_sticky), .instr_count(instr_count)
   );

   instr_encoder_loader #(.ADDR_WIDTH(4), .BASE_ADDR(4'hC)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready4),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .flush(flush), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
      .mem_ack(mem_ack), .busy(busy4), .err_pulse(ep4),
      .err_sticky(es4), .instr_count(cnt4)
   );

   task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready got %b want 1", in_ready);
      end
      in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expect_write(input logic [31:0] w, input string name);
      int n = 0;
      while (mem_we !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_we !== 1'b1) begin
         errors++;
         $display("FAIL %s_we_timeout got %b want 1", name, mem_we);
      end
      checks++;
      if (mem_wdata !== w || wdata4 !== w) begin
         errors++;
         $display("FAIL %s_data got %h/%h want %h", name, mem_wdata, wdata4, w);
      end
      checks++;
      if (mem_addr !== exp_addr || addr4 !== exp_addr4) begin
         errors++;
         $display("FAIL %s_addr got %h/%h want %h/%h", name, mem_addr, addr4, exp_addr, exp_addr4);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy got busy=%b ready=%b want 1/0", name, busy, in_ready);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      exp_addr  = exp_addr + 10'd4;
      exp_addr4 = exp_addr4 + 4'd4;
      exp_count = exp_count + 16'd1;
      checks++;
      if (mem_we !== 1'b0 || instr_count !== exp_count || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_done got we=%b cnt=%0d ready=%b want 0/%0d/1",
                  name, mem_we, instr_count, in_ready, exp_count);
      end
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      exp_addr = 10'h000; exp_addr4 = 4'hC; exp_count = 16'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'h000 || mem_wdata !== 32'h0 ||
          instr_count !== 16'd0 || err_pulse !== 1'b0 || err_sticky !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b we=%b a=%h d=%h c=%0d ep=%b es=%b bz=%b want all zero",
                  in_ready, mem_we, mem_addr, mem_wdata, instr_count, err_pulse, err_sticky, busy);
      end
      checks++;
      if (addr4 !== 4'hC || ready4 !== 1'b0 || we4 !== 1'b0 || cnt4 !== 16'd0 ||
          busy4 !== 1'b0 || ep4 !== 1'b0 || es4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state4 got addr=%h rdy=%b we=%b want c/0/0", addr4, ready4, we4);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_encode();
      // addi x1,x0,5 with junk rs2/funct7 that I-format must ignore
      drive(7'b0010011, 5'd1, 5'd0, 5'd31, 3'b000, 7'h7F, 32'd5);
      expect_write(32'h00500093, "addi");
      drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8);
      expect_write(32'h0020A423, "sw");
      drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0);
      expect_write(32'h002081B3, "add");
      drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345000);
      expect_write(32'h123452B7, "lui");
      drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFFFFFC);
      expect_write(32'hFE000EE3, "beq");
      drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd8);
      expect_write(32'h008000EF, "jal");
   endtask

   task automatic check_error(input string name);
      @(negedge clk);
      checks++;
      if (err_pulse !== 1'b1 || err_sticky !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr) begin
         errors++;
         $display("FAIL %s_err got ep=%b es=%b we=%b a=%h want 1/1/0/%h",
                  name, err_pulse, err_sticky, mem_we, mem_addr, exp_addr);
      end
      @(negedge clk);
      checks++;
      if (err_pulse !== 1'b0 || err_sticky !== 1'b1 || in_ready !== 1'b1 ||
          instr_count !== exp_count || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL %s_after got ep=%b es=%b rdy=%b c=%0d want 0/1/1/%0d",
                  name, err_pulse, err_sticky, in_ready, instr_count, exp_count);
      end
   endtask

   task automatic test_bad_opcode();
      drive(7'b1111111, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'd0);
      check_error("badop");
   endtask

   task automatic test_range();
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048);
`ifdef INSTR_ENC_RANGE_CHECK_EN
      check_error("range");
`else
      expect_write(32'h80000093, "trunc");
`endif
   endtask

   task automatic test_stall_flush();
      int n = 0;
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1);
      while (mem_we !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b1 || mem_wdata !== 32'h00100093 || mem_addr !== exp_addr || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got we=%b d=%h a=%h rdy=%b want 1/00100093/%h/0",
                     i, mem_we, mem_wdata, mem_addr, in_ready, exp_addr);
         end
      end
      expect_write(32'h00100093, "stall");
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1);
      n = 0;
      while (mem_we !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      flush = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      mem_ack = 1'b0;
      exp_addr = 10'h000; exp_addr4 = 4'hC; exp_count = 16'd0;
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 10'h000 || addr4 !== 4'hC || instr_count !== 16'd0 ||
          err_sticky !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush got we=%b a=%h a4=%h c=%0d es=%b bz=%b rdy=%b want 0/0/c/0/0/0/1",
                  mem_we, mem_addr, addr4, instr_count, err_sticky, busy, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      // Idle ack must be ignored
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (instr_count !== exp_count || mem_addr !== exp_addr) begin
         errors++;
         $display("FAIL idle_ack got c=%0d a=%h want %0d/%h", instr_count, mem_addr, exp_count, exp_addr);
      end
      in_valid = 1'b1; in_opcode = 7'b0010011; in_rd = 5'd1; in_rs1 = 5'd0;
      in_rs2 = 5'd0; in_funct3 = 3'b000; in_funct7 = 7'h00; in_imm = 32'd5;
      mem_ack = 1'b1;
      repeat (9) @(negedge clk);
      in_valid = 1'b0;
      mem_ack = 1'b0;
      exp_count = exp_count + 16'd3;
      exp_addr  = exp_addr + 10'd12;
      exp_addr4 = exp_addr4 + 4'd12;
      checks++;
      if (instr_count !== exp_count || mem_addr !== exp_addr || addr4 !== exp_addr4 ||
          busy !== 1'b0 || mem_wdata !== 32'h00500093) begin
         errors++;
         $display("FAIL back_to_back got c=%0d a=%h a4=%h bz=%b d=%h want %0d/%h/%h/0/00500093",
                  instr_count, mem_addr, addr4, busy, mem_wdata, exp_count, exp_addr, exp_addr4);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] words [5];
      words = '{32'h00100113, 32'h00200113, 32'h00300113, 32'h00400113, 32'h00500113};
      do_flush();
      for (int k = 0; k < 5; k++) begin
         drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'(k + 1));
         expect_write(words[k], "wrap");
      end
      checks++;
      if (addr4 !== 4'h0 || cnt4 !== 16'd5) begin
         errors++;
         $display("FAIL wrap_end got a4=%h c4=%0d want 0/5", addr4, cnt4);
      end
   endtask

   task automatic test_reset_mid_write();
      int n = 0;
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd7);
      while (mem_we !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0 || in_ready !== 1'b0 || mem_addr !== 10'h000) begin
         errors++;
         $display("FAIL reset_mid got we=%b rdy=%b a=%h want 0/0/0", mem_we, in_ready, mem_addr);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_addr = 10'h000; exp_addr4 = 4'hC; exp_count = 16'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b0 || busy !== 1'b0 || instr_count !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_noretry%0d got we=%b bz=%b c=%0d rdy=%b want 0/0/0/1",
                     i, mem_we, busy, instr_count, in_ready);
         end
      end
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5);
      expect_write(32'h00500093, "after_reset");
   endtask

   initial begin
      test_reset();
      test_encode();
      test_bad_opcode();
      test_range();
      test_stall_flush();
      test_back_to_back();
      test_wrap();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
